// File: rtl/word_arith_sequencer.sv
// Sequential evaluator of r = (((x+1)**2 * (x-2)) / DIV_CONST) % (x+1) on one shared W-bit ALU.
// Optional mod-by-zero flag output out_err is enabled by defining WORD_ARITH_ERR_EN.
module word_arith_sequencer #(
    parameter int W         = 8,
    parameter int DIV_CONST = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
`ifdef WORD_ARITH_ERR_EN
    ,
    output logic         out_err
`endif
);

    // state  | meaning
    // S_IDLE | waiting for x (in_ready=1)
    // S_ADD  | t0  <= x + 1
    // S_SUB  | t1  <= x - 2
    // S_POW  | acc <= t0 * t0
    // S_MUL  | acc <= acc * t1
    // S_DIV  | acc <= acc / DIV_CONST
    // S_MOD  | out_data <= acc % t0 (acc when t0 == 0)
    // S_DONE | result offered until out_ready
    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SUB, S_POW, S_MUL, S_DIV, S_MOD, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_POW, OP_MUL, OP_DIV, OP_MOD
    } op_t;

    state_t       r_state;
    state_t       w_state_nxt;
    op_t          w_op;
    logic [W-1:0] w_op_a;
    logic [W-1:0] w_op_b;
    logic [W-1:0] w_alu_y;

    logic [W-1:0] r_x;
    logic [W-1:0] r_t0;
    logic [W-1:0] r_t1;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_out_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op        = OP_ADD;
        w_op_a      = '0;
        w_op_b      = '0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_ADD;
            end
            S_ADD: begin
                w_op = OP_ADD; w_op_a = r_x; w_op_b = W'(1);
                w_state_nxt = S_SUB;
            end
            S_SUB: begin
                w_op = OP_SUB; w_op_a = r_x; w_op_b = W'(2);
                w_state_nxt = S_POW;
            end
            S_POW: begin
                w_op = OP_POW; w_op_a = r_t0; w_op_b = r_t0;
                w_state_nxt = S_MUL;
            end
            S_MUL: begin
                w_op = OP_MUL; w_op_a = r_acc; w_op_b = r_t1;
                w_state_nxt = S_DIV;
            end
            S_DIV: begin
                w_op = OP_DIV; w_op_a = r_acc; w_op_b = W'(DIV_CONST);
                w_state_nxt = S_MOD;
            end
            S_MOD: begin
                w_op = OP_MOD; w_op_a = r_acc; w_op_b = r_t0;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Zero divisors are trapped so no X ever reaches the result registers.
    always_comb begin
        w_alu_y = '0;
        case (w_op)
            OP_ADD: w_alu_y = w_op_a + w_op_b;
            OP_SUB: w_alu_y = w_op_a - w_op_b;
            OP_POW: w_alu_y = w_op_a * w_op_a;
            OP_MUL: w_alu_y = w_op_a * w_op_b;
            OP_DIV: w_alu_y = (w_op_b == '0) ? '1 : w_op_a / w_op_b;
            OP_MOD: w_alu_y = (w_op_b == '0) ? w_op_a : w_op_a % w_op_b;
            default: w_alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_t0       <= '0;
            r_t1       <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE:                 if (in_valid) r_x <= in_data;
                S_ADD:                  r_t0 <= w_alu_y;
                S_SUB:                  r_t1 <= w_alu_y;
                S_POW, S_MUL, S_DIV:    r_acc <= w_alu_y;
                S_MOD:                  r_out_data <= w_alu_y;
                default: ;
            endcase
        end
    end

    assign out_data = r_out_data;

`ifdef WORD_ARITH_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)                                 r_err <= 1'b0;
        else if (r_state == S_MOD)               r_err <= (r_t0 == '0);
        else if (r_state == S_DONE && out_ready) r_err <= 1'b0;
    end

    assign out_err = r_err;
`endif

endmodule

// File: tb/tb_word_arith_sequencer.sv
// Directed scoreboard bench for word_arith_sequencer (W=8, DIV_CONST=3).
// Checks out_err too when WORD_ARITH_ERR_EN is defined.
module tb_word_arith_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef WORD_ARITH_ERR_EN
    logic       out_err;
`endif

    word_arith_sequencer #(.W(8), .DIV_CONST(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef WORD_ARITH_ERR_EN
        ,
        .out_err   (out_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic e);
`ifdef WORD_ARITH_ERR_EN
        check(tag, out_err, e);
`endif
    endtask

    task automatic send(input string tag, input logic [7:0] x, input logic [7:0] d, input logic e);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = x;
        acc_cyc  = cyc;
        sb.push_back(exp_t'{d, e});
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 0);
    endtask

    task automatic recv(input string tag);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_latency"}, cyc - acc_cyc, 7);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, out_data, e.d);
            check_err({tag, "_err"}, e.e);
        end
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_valid_drop"}, out_valid, 0);
            check_err({tag, "_err_clear"}, 1'b0);
        end
    endtask

    logic err_ff;
    logic held;
    int   prev_acc;

    initial begin
`ifdef WORD_ARITH_ERR_EN
        err_ff = 1'b1;
`else
        err_ff = 1'b0;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        // T1: reset values
        repeat (2) @(negedge clk);
        check("t1_in_ready", in_ready, 1);
        check("t1_out_valid", out_valid, 0);
        check("t1_out_data", out_data, 8'h00);
        check_err("t1_out_err", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // T2: x=7 -> 5
        send("t2", 8'h07, 8'h05, 1'b0);
        recv("t2");

        // T3: x=5 then x=0 offered back to back
        send("t3a", 8'h05, 8'h00, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        recv("t3a");
        check("t3b_in_ready", in_ready, 1);
        check("t3b_out_valid_low", out_valid, 0);
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        check("t3b_throughput", acc_cyc - prev_acc, 8);
        sb.push_back(exp_t'{8'h00, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        check("t3b_busy", in_ready, 0);
        recv("t3b");

        // T4: x=0xFF -> mod by zero
        send("t4", 8'hFF, 8'h00, err_ff);
        recv("t4");

        // T5: result held while sink stalls, in_valid pulses ignored
        out_ready = 1'b0;
        send("t5", 8'h01, 8'h00, 1'b0);
        recv("t5");
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = 8'h33;
            held &= (out_valid === 1'b1) && (out_data === 8'h00) && (in_ready === 1'b0);
        end
        in_valid = 1'b0;
        check("t5_hold", held, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_valid_drop", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_sb_empty", sb.size(), 0);

        // T6: reset during MUL aborts the operation
        check("t6_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 8'h00);
        check_err("t6_rst_out_err", 1'b0);
        send("t6", 8'h07, 8'h05, 1'b0);
        recv("t6");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
